// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int DEPTH  = 16;
  localparam int PC_W   = $clog2(DEPTH);
  localparam int OPR_W  = 4;
  localparam int OPA_W  = 4;
  localparam int WORD_W = OPR_W + OPA_W;

  localparam logic [WORD_W-1:0] HALT_WORD = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/inst_fetch_prog_mem.sv
// Program memory: synchronous write, asynchronous read, contents survive reset.
module inst_fetch_prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: presents one program word per cycle to execute with
// valid/ready handshake, jump redirect, and halt on HALT_WORD.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                  DEPTH     = inst_fetch_pkg::DEPTH,
  parameter logic [WORD_W-1:0]   HALT_WORD = inst_fetch_pkg::HALT_WORD,
  localparam int                 AW        = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LD_EN,
  input  logic [AW-1:0]     LD_ADDR,
  input  logic [WORD_W-1:0] LD_DATA,
  input  logic              START,
  input  logic              JMP_EN,
  input  logic [AW-1:0]     JMP_ADDR,
  input  logic              INST_READY,
  output logic              INST_VALID,
  output logic [OPR_W-1:0]  OPR,
  output logic [OPA_W-1:0]  OPA,
  output logic [AW-1:0]     PC,
  output logic              BUSY,
  output logic              HALTED
);

  state_e             state_q, state_d;
  logic               vld_q, vld_d;
  logic [OPR_W-1:0]   opr_q, opr_d;
  logic [OPA_W-1:0]   opa_q, opa_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic               mem_we;
  logic [AW-1:0]      rd_addr;
  logic [WORD_W-1:0]  rd_data;
  logic               load;

  inst_fetch_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (WORD_W)
  ) prog_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (LD_ADDR),
    .wdata (LD_DATA),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Single read port: address is muxed between 0 (start), jump target and PC+1.
  // The read is combinational, so a coincident write is not seen by this fetch.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    pc_d    = pc_q;
    rd_addr = pc_q + 1'b1;
    mem_we  = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        mem_we = LD_EN;
        if (START) begin
          state_d = ST_FETCH;
          rd_addr = '0;
          load    = 1'b1;
        end
      end
      ST_FETCH: begin
        if (JMP_EN) begin
          rd_addr = JMP_ADDR;
          load    = 1'b1;
        end else if (vld_q && INST_READY) begin
          if ({opr_q, opa_q} == HALT_WORD) begin
            state_d = ST_HALT;
            vld_d   = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      pc_d           = rd_addr;
      {opr_d, opa_d} = rd_data;
      vld_d          = 1'b1;
    end

    if (!RST_N) mem_we = 1'b0;

    busy_d   = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      vld_q    <= 1'b0;
      opr_q    <= '0;
      opa_q    <= '0;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      opr_q    <= opr_d;
      opa_q    <= opa_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign INST_VALID = vld_q;
  assign OPR        = opr_q;
  assign OPA        = opa_q;
  assign PC         = pc_q;
  assign BUSY       = busy_q;
  assign HALTED     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed program scenarios then random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_inst_fetch;

  logic       CLK = 1'b0;
  logic       RST_N, LD_EN, START, JMP_EN, INST_READY;
  logic [3:0] LD_ADDR, JMP_ADDR;
  logic [7:0] LD_DATA;
  logic       INST_VALID, BUSY, HALTED;
  logic [3:0] OPR, OPA, PC;

  always #5 CLK = ~CLK;

  inst_fetch dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LD_EN      (LD_EN),
    .LD_ADDR    (LD_ADDR),
    .LD_DATA    (LD_DATA),
    .START      (START),
    .JMP_EN     (JMP_EN),
    .JMP_ADDR   (JMP_ADDR),
    .INST_READY (INST_READY),
    .INST_VALID (INST_VALID),
    .OPR        (OPR),
    .OPA        (OPA),
    .PC         (PC),
    .BUSY       (BUSY),
    .HALTED     (HALTED)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 fetching, 2 halted
  bit [7:0] m_mem [16];
  int       m_st   = 0;
  bit       m_vld  = 0;
  bit [7:0] m_word = 0;
  bit [3:0] m_pc   = 0;

  task automatic model_step();
    bit [7:0] w0;
    if (!RST_N) begin
      m_st = 0; m_vld = 0; m_word = 0; m_pc = 0;
    end else if (m_st != 1) begin
      w0 = m_mem[0];
      if (LD_EN) m_mem[LD_ADDR] = LD_DATA;
      if (START) begin
        m_st = 1; m_vld = 1; m_pc = 0; m_word = w0;
      end
    end else if (JMP_EN) begin
      m_pc = JMP_ADDR; m_word = m_mem[JMP_ADDR]; m_vld = 1;
    end else if (m_vld && INST_READY) begin
      if (m_word == 8'h00) begin
        m_st = 2; m_vld = 0;
      end else begin
        m_pc   = m_pc + 4'd1;
        m_word = m_mem[m_pc];
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    chk("INST_VALID", INST_VALID, m_vld);
    chk("OPR", OPR, m_word[7:4]);
    chk("OPA", OPA, m_word[3:0]);
    chk("PC", PC, m_pc);
    chk("BUSY", BUSY, (m_st == 1));
    chk("HALTED", HALTED, (m_st == 2));
  endtask

  task automatic quiet();
    RST_N = 1'b1; LD_EN = 1'b0; START = 1'b0; JMP_EN = 1'b0; INST_READY = 1'b1;
  endtask

  task automatic expect_inst(input string tag, input logic [7:0] word, input logic [3:0] pc);
    chk(tag, {INST_VALID, OPR, OPA, PC}, {1'b1, word, pc});
  endtask

  task automatic run_to_halt(input string tag);
    for (int i = 0; i < 20 && !HALTED; i++) cycle();
    chk(tag, HALTED, 1'b1);
  endtask

  task automatic do_start();
    START = 1'b1; cycle(); START = 1'b0;
  endtask

  initial begin
    LD_ADDR = '0; LD_DATA = '0; JMP_ADDR = '0;
    quiet();
    RST_N = 1'b0; START = 1'b1; JMP_EN = 1'b1;
    cycle(); cycle();
    chk("reset_state", {INST_VALID, OPR, OPA, PC, BUSY, HALTED}, '0);
    quiet();

    for (int a = 0; a < 16; a++) begin
      LD_EN = 1'b1; LD_ADDR = 4'(a);
      case (a)
        0: LD_DATA = 8'h1D;
        1: LD_DATA = 8'h20;
        2: LD_DATA = 8'h17;
        3: LD_DATA = 8'h40;
        4: LD_DATA = 8'h00;
        15: LD_DATA = 8'h31;
        default: LD_DATA = 8'hA5;
      endcase
      cycle();
    end
    quiet();
    chk("idle_after_load", {INST_VALID, BUSY, HALTED}, 3'b000);

    // Straight-line program
    do_start();            expect_inst("seq0", 8'h1D, 4'd0);
    cycle();               expect_inst("seq1", 8'h20, 4'd1);
    cycle();               expect_inst("seq2", 8'h17, 4'd2);
    cycle();               expect_inst("seq3", 8'h40, 4'd3);
    cycle();               expect_inst("seq4", 8'h00, 4'd4);
    cycle();
    chk("seq_halt", {HALTED, INST_VALID, PC}, {1'b1, 1'b0, 4'd4});

    // Jump ignored while halted
    JMP_EN = 1'b1; JMP_ADDR = 4'd2; cycle(); quiet();
    chk("halt_jmp_ignored", {HALTED, INST_VALID}, 2'b10);

    // Back-pressure at PC=2
    do_start(); cycle(); cycle();
    expect_inst("bp_pc2", 8'h17, 4'd2);
    INST_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(); expect_inst("bp_hold", 8'h17, 4'd2);
    end
    INST_READY = 1'b1;
    cycle();               expect_inst("bp_resume3", 8'h40, 4'd3);
    cycle();               expect_inst("bp_resume4", 8'h00, 4'd4);
    run_to_halt("bp_halt");

    // Jump from PC=1 to 4 skips entry 2
    do_start(); cycle();
    expect_inst("jmp_pc1", 8'h20, 4'd1);
    JMP_EN = 1'b1; JMP_ADDR = 4'd4;
    cycle(); quiet();
    expect_inst("jmp_to4", 8'h00, 4'd4);
    run_to_halt("jmp_halt");

    // Jump to F, PC wraps to 0
    do_start();
    JMP_EN = 1'b1; JMP_ADDR = 4'hF;
    cycle(); quiet();
    expect_inst("wrap_F", 8'h31, 4'hF);
    cycle();               expect_inst("wrap_0", 8'h1D, 4'h0);
    run_to_halt("wrap_halt");

    // Mid-stream reset, memory retained
    do_start(); cycle(); cycle(); cycle();
    expect_inst("rst_pc3", 8'h40, 4'd3);
    RST_N = 1'b0; cycle(); quiet();
    chk("rst_mid", {INST_VALID, PC, BUSY, HALTED}, '0);
    cycle();
    chk("rst_no_restart", {INST_VALID, BUSY}, 2'b00);
    do_start();            expect_inst("rst_restart", 8'h1D, 4'd0);

    // Load during FETCH is ignored
    INST_READY = 1'b0; LD_EN = 1'b1; LD_ADDR = 4'd0; LD_DATA = 8'h55;
    cycle(); quiet();
    run_to_halt("ld_fetch_halt");
    do_start();            expect_inst("ld_fetch_ignored", 8'h1D, 4'd0);
    run_to_halt("ld_fetch_halt2");

    // START + load together: fetch sees old word, write lands
    START = 1'b1; LD_EN = 1'b1; LD_ADDR = 4'd0; LD_DATA = 8'h55;
    cycle(); quiet();
    expect_inst("start_ld_old", 8'h1D, 4'd0);
    run_to_halt("start_ld_halt");
    do_start();            expect_inst("start_ld_new", 8'h55, 4'd0);
    run_to_halt("start_ld_halt2");
    LD_EN = 1'b1; LD_ADDR = 4'd0; LD_DATA = 8'h1D; cycle(); quiet();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      RST_N      = ($urandom % 64) != 0;
      LD_EN      = ($urandom % 4) == 0;
      LD_ADDR    = 4'($urandom);
      LD_DATA    = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      START      = ($urandom % 8) == 0;
      JMP_EN     = ($urandom % 8) == 0;
      JMP_ADDR   = 4'($urandom);
      INST_READY = ($urandom % 4) != 0;
      cycle();
    end
    quiet();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
